// File: rtl/twofish_mds_inv.sv
// Inverse Twofish MDS transform over GF(2^8).
// After reset the block builds the 4x4 inverse by Gauss-Jordan elimination of
// the fixed forward matrix. It then serves byte-serial matrix-vector products
// behind a valid/ready handshake, one output byte per cycle.
module twofish_mds_inv #(
    parameter logic [8:0] POLY     = 9'h169,
    parameter int         MAX_INIT = 2048
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        init_done,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] z_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y_out
);

    // Forward MDS rows packed row-major, byte 0 of row 0 in the top byte.
    localparam logic [127:0] FWD = 128'h01EF5B5B_5BEFEF01_EF5B01EF_EF01EF5B;
    localparam int CNT_W = $clog2(MAX_INIT + 1);

    typedef enum logic [2:0] {
        S_PIVOT,
        S_INV,
        S_SCALE,
        S_ELIM,
        S_COPY,
        S_RUN
    } state_t;

    // Shift-and-add multiply, reducing by POLY whenever bit 7 carries out.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = sh[7] ? ({sh[6:0], 1'b0} ^ POLY[7:0]) : {sh[6:0], 1'b0};
        end
        return acc;
    endfunction

    state_t state_reg, state_next;

    // Augmented matrix [M | I]; columns 4..7 end up holding the inverse.
    logic [7:0] m_reg     [4][8];
    logic [7:0] inv_m_reg [4][4];
    logic [1:0] col_reg;
    logic [3:0] step_reg;
    logic [1:0] elim_reg;
    logic [7:0] acc_reg;

    logic [31:0] z_reg;
    logic [31:0] y_acc_reg;
    logic [31:0] y_reg;
    logic [1:0]  k_reg;
    logic        busy_reg;
    logic        out_valid_reg;
    logic [CNT_W-1:0] init_cnt_reg;

    logic [1:0] piv_row;
    logic       piv_found;
    logic [7:0] pivot;
    logic [7:0] inv_a;
    logic [7:0] inv_b;
    logic [7:0] inv_prod;
    logic [1:0] elim_row;
    logic [7:0] elim_factor;
    logic [7:0] scale_val [8];
    logic [7:0] elim_val  [8];
    logic [7:0] run_prod  [4];
    logic [7:0] y_byte;

    // Pivot search: lowest row at or below col with a nonzero entry in col.
    always_comb begin
        piv_found = 1'b0;
        piv_row   = col_reg;
        for (int r = 3; r >= 0; r--) begin
            if (r >= int'(col_reg) && m_reg[r][col_reg] != 8'h00) begin
                piv_found = 1'b1;
                piv_row   = 2'(r);
            end
        end
    end

    // Inversion schedule: step 0 loads p, then square / multiply-by-p
    // alternate, ending with a square, which yields p^254 after 14 steps.
    assign pivot    = m_reg[col_reg][col_reg];
    assign inv_a    = (step_reg == 4'd0) ? 8'h01 : acc_reg;
    assign inv_b    = step_reg[0] ? acc_reg : pivot;
    assign inv_prod = gf_mul(inv_a, inv_b);

    // Elimination walks the three rows other than col in ascending order.
    assign elim_row    = elim_reg + {1'b0, (elim_reg >= col_reg)};
    assign elim_factor = m_reg[elim_row][col_reg];

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_row_ops
            assign scale_val[gi] = gf_mul(m_reg[col_reg][gi], acc_reg);
            assign elim_val[gi]  = m_reg[elim_row][gi] ^ gf_mul(elim_factor, m_reg[col_reg][gi]);
        end
        for (genvar gi = 0; gi < 4; gi++) begin : g_run_mul
            assign run_prod[gi] = gf_mul(inv_m_reg[k_reg][gi], z_reg[31-8*gi -: 8]);
        end
    endgenerate

    // Dot product of inverse row k with the latched input word.
    always_comb begin
        y_byte = 8'h00;
        for (int j = 0; j < 4; j++) begin
            y_byte = y_byte ^ run_prod[j];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= S_PIVOT;
        else        state_reg <= state_next;
    end

    // Next-state logic: fixed-length init sequence per column, then RUN forever.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_PIVOT: state_next = S_INV;
            S_INV:   if (step_reg == 4'd13) state_next = S_SCALE;
            S_SCALE: state_next = S_ELIM;
            S_ELIM:  if (elim_reg == 2'd2) state_next = (col_reg == 2'd3) ? S_COPY : S_PIVOT;
            S_COPY:  state_next = S_RUN;
            S_RUN:   state_next = S_RUN;
            default: state_next = S_PIVOT;
        endcase
    end

    // Output decode: handshake opens only once the inverse is in place.
    always_comb begin
        init_done = (state_reg == S_RUN);
        in_ready  = init_done && !busy_reg && (!out_valid_reg || out_ready);
    end

    assign out_valid = out_valid_reg;
    assign y_out     = y_reg;

    // Datapath: matrix elimination during init, byte-serial products in RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    m_reg[i][j]     <= FWD[127-32*i-8*j -: 8];
                    m_reg[i][j+4]   <= (i == j) ? 8'h01 : 8'h00;
                    inv_m_reg[i][j] <= 8'h00;
                end
            end
            col_reg       <= 2'd0;
            step_reg      <= 4'd0;
            elim_reg      <= 2'd0;
            acc_reg       <= 8'h00;
            z_reg         <= 32'h0;
            y_acc_reg     <= 32'h0;
            y_reg         <= 32'h0;
            k_reg         <= 2'd0;
            busy_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_PIVOT: begin
                    for (int j = 0; j < 8; j++) begin
                        m_reg[col_reg][j] <= m_reg[piv_row][j];
                        m_reg[piv_row][j] <= m_reg[col_reg][j];
                    end
                    step_reg <= 4'd0;
                end
                S_INV: begin
                    acc_reg  <= inv_prod;
                    step_reg <= step_reg + 4'd1;
                end
                S_SCALE: begin
                    for (int j = 0; j < 8; j++) begin
                        m_reg[col_reg][j] <= scale_val[j];
                    end
                    elim_reg <= 2'd0;
                end
                S_ELIM: begin
                    for (int j = 0; j < 8; j++) begin
                        m_reg[elim_row][j] <= elim_val[j];
                    end
                    elim_reg <= elim_reg + 2'd1;
                    if (elim_reg == 2'd2) col_reg <= col_reg + 2'd1;
                end
                S_COPY: begin
                    for (int i = 0; i < 4; i++) begin
                        for (int j = 0; j < 4; j++) begin
                            inv_m_reg[i][j] <= m_reg[i][j+4];
                        end
                    end
                end
                S_RUN: begin
                    if (busy_reg) begin
                        y_acc_reg[8*(3-int'(k_reg)) +: 8] <= y_byte;
                        k_reg <= k_reg + 2'd1;
                        if (k_reg == 2'd3) begin
                            busy_reg      <= 1'b0;
                            out_valid_reg <= 1'b1;
                            y_reg         <= {y_acc_reg[31:8], y_byte};
                        end
                    end else begin
                        if (out_valid_reg && out_ready) out_valid_reg <= 1'b0;
                        if (in_valid && in_ready) begin
                            z_reg    <= z_in;
                            busy_reg <= 1'b1;
                            k_reg    <= 2'd0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Cycles spent initialising, saturating; only observed by the bound check.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                  init_cnt_reg <= '0;
        else if (!init_done && init_cnt_reg != '1)   init_cnt_reg <= init_cnt_reg + CNT_W'(1);
    end

    assert property (@(posedge clk) disable iff (!rst_n)
        (state_reg == S_PIVOT) |-> piv_found);

    assert property (@(posedge clk) disable iff (!rst_n)
        !init_done |-> (int'(init_cnt_reg) < MAX_INIT));

endmodule

// File: tb/tb_twofish_mds_inv.sv
// Directed and randomised checks for the inverse MDS block; expected values
// come from hand-derived vectors and an independent forward-MDS model.
module tb_twofish_mds_inv;

    localparam int MAX_INIT = 2048;
    localparam int N_RT     = 1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] z_in = 32'h0;
    logic        init_done;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] y_out;

    int checks = 0;
    int passes = 0;
    int base_init = -1;

    logic [7:0] fm [4][4] = '{'{8'h01, 8'hEF, 8'h5B, 8'h5B},
                              '{8'h5B, 8'hEF, 8'hEF, 8'h01},
                              '{8'hEF, 8'h5B, 8'h01, 8'hEF},
                              '{8'hEF, 8'h01, 8'hEF, 8'h5B}};

    always #5 clk = ~clk;

    twofish_mds_inv #(.POLY(9'h169), .MAX_INIT(MAX_INIT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_done (init_done),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .z_in      (z_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y_out     (y_out)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] s;
        r = 8'h00;
        s = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ s;
            s = s[7] ? ({s[6:0], 1'b0} ^ 8'h69) : {s[6:0], 1'b0};
        end
        return r;
    endfunction

    // Forward MDS: z_i = XOR_j fm[i][j] * y_j
    function automatic logic [31:0] fwd(input logic [31:0] y);
        logic [31:0] z;
        logic [7:0]  b;
        z = 32'h0;
        for (int i = 0; i < 4; i++) begin
            b = 8'h00;
            for (int j = 0; j < 4; j++) b = b ^ gmul(fm[i][j], y[31-8*j -: 8]);
            z[31-8*i -: 8] = b;
        end
        return z;
    endfunction

    // Starting with rst_n low, hold it two more edges, release, and count
    // edges until init_done, noting any handshake activity along the way.
    task automatic wait_init(output int cycles, output bit early_ready, output bit early_valid);
        repeat (2) @(posedge clk);
        #1;
        rst_n       = 1'b1;
        in_valid    = 1'b1;
        z_in        = 32'h5B01EF5B;
        out_ready   = 1'b1;
        cycles      = 0;
        early_ready = 1'b0;
        early_valid = 1'b0;
        while (!init_done && cycles < MAX_INIT + 16) begin
            if (in_ready)  early_ready = 1'b1;
            if (out_valid) early_valid = 1'b1;
            @(posedge clk);
            #1;
            cycles++;
        end
        in_valid  = 1'b0;
        z_in      = 32'h0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        int  cyc;
        bit  er;
        bit  ev;
        for (int it = 0; it < 3; it++) begin
            @(posedge clk);
            #1;
            rst_n = 1'b0;
            #2;
            checks++;
            if ({init_done, in_ready, out_valid} !== 3'b000 || y_out !== 32'h0) begin
                $display("FAIL reset_state[%0d]: init_done=%b in_ready=%b out_valid=%b y_out=%h, required 0 0 0 00000000",
                         it, init_done, in_ready, out_valid, y_out);
            end else passes++;
            wait_init(cyc, er, ev);
            if (it == 0) base_init = cyc;
            checks++;
            if (cyc >= MAX_INIT || cyc <= 0) begin
                $display("FAIL init_bound[%0d]: took %0d cycles, required 1..%0d", it, cyc, MAX_INIT - 1);
            end else passes++;
            checks++;
            if (cyc !== base_init) begin
                $display("FAIL init_constant[%0d]: took %0d cycles, required %0d", it, cyc, base_init);
            end else passes++;
            checks++;
            if (er !== 1'b0 || ev !== 1'b0) begin
                $display("FAIL pre_init_quiet[%0d]: in_ready seen=%b out_valid seen=%b, required 0 0", it, er, ev);
            end else passes++;
            $display("reset %0d: init took %0d cycles", it, cyc);
        end
    endtask

    task automatic test_directed();
        logic [31:0] zv [4];
        logic [31:0] yv [4];
        int wait_cyc;
        int lat;
        zv = '{32'h5B01EF5B, 32'h015BEFEF, 32'h5A5A00B4, 32'h00000000};
        yv = '{32'h00000001, 32'h01000000, 32'h01000001, 32'h00000000};
        for (int i = 0; i < 4; i++) begin
            in_valid  = 1'b1;
            z_in      = zv[i];
            out_ready = 1'b0;
            #1;
            wait_cyc = 0;
            while (!in_ready && wait_cyc < 50) begin
                @(posedge clk);
                #2;
                wait_cyc++;
            end
            checks++;
            if (wait_cyc >= 50) $display("FAIL accept_wait[%0d]: in_ready stayed %b, required 1", i, in_ready);
            else passes++;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            z_in     = 32'h0;
            lat = 0;
            while (!out_valid && lat < 20) begin
                @(posedge clk);
                #1;
                lat++;
            end
            checks++;
            if (lat !== 4) $display("FAIL latency[%0d]: out_valid after %0d edges, required 4", i, lat);
            else passes++;
            checks++;
            if (y_out !== yv[i]) $display("FAIL vector[%0d]: z=%h y_out=%h, required %h", i, zv[i], y_out, yv[i]);
            else passes++;
            repeat (2) @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || y_out !== yv[i] || in_ready !== 1'b0) begin
                $display("FAIL hold[%0d]: out_valid=%b y_out=%h in_ready=%b, required 1 %h 0",
                         i, out_valid, y_out, in_ready, yv[i]);
            end else passes++;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            checks++;
            if (out_valid !== 1'b0) $display("FAIL consume[%0d]: out_valid=%b, required 0", i, out_valid);
            else passes++;
            $display("vector %0d: z=%h y=%h latency=%0d", i, zv[i], y_out, lat);
        end
    endtask

    task automatic test_round_trip();
        logic [31:0] exp_q [$];
        logic [31:0] cur_y;
        logic [31:0] held_y;
        bit          hold;
        int          sent;
        int          recv;
        int          cyc;
        int          errs;
        sent  = 0;
        recv  = 0;
        cyc   = 0;
        errs  = 0;
        hold  = 1'b0;
        held_y = 32'h0;
        cur_y = $urandom;
        while (recv < N_RT && cyc < 40000) begin
            if (hold) begin
                checks++;
                if (out_valid !== 1'b1 || y_out !== held_y) begin
                    errs++;
                    $display("FAIL rt_stable: out_valid=%b y_out=%h, required 1 %h", out_valid, y_out, held_y);
                end else passes++;
            end
            in_valid  = (sent < N_RT) && ($urandom_range(0, 3) != 0);
            z_in      = fwd(cur_y);
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (out_valid && !out_ready) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errs++;
                    $display("FAIL rt_stall_ready: in_ready=%b while stalled, required 0", in_ready);
                end else passes++;
            end
            hold   = out_valid && !out_ready;
            held_y = y_out;
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errs++;
                    $display("FAIL rt_order: unexpected y_out=%h with nothing outstanding", y_out);
                end else if (y_out !== exp_q[0]) begin
                    errs++;
                    $display("FAIL rt_value[%0d]: y_out=%h, required %h", recv, y_out, exp_q[0]);
                end else passes++;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                recv++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(cur_y);
                sent++;
                cur_y = $urandom;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (recv !== N_RT || exp_q.size() != 0) begin
            $display("FAIL rt_count: received %0d with %0d outstanding, required %0d and 0", recv, exp_q.size(), N_RT);
        end else passes++;
        $display("round trip: sent=%0d received=%0d cycles=%0d errors=%0d", sent, recv, cyc, errs);
    endtask

    task automatic test_back_to_back();
        logic [31:0] ylist [6];
        logic [31:0] exp_q [$];
        int          acc_q [$];
        int          sent;
        int          recv;
        int          cyc;
        for (int i = 0; i < 6; i++) ylist[i] = $urandom;
        sent = 0;
        recv = 0;
        cyc  = 0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        while (recv < 6 && cyc < 200) begin
            in_valid = (sent < 6);
            z_in     = fwd(ylist[(sent < 6) ? sent : 5]);
            #1;
            if (out_valid) begin
                checks++;
                if (exp_q.size() == 0 || y_out !== exp_q[0]) begin
                    $display("FAIL b2b_value[%0d]: y_out=%h, required %h", recv, y_out,
                             (exp_q.size() != 0) ? exp_q[0] : 32'h0);
                end else passes++;
                // Accept decision at cycle a means the accept edge is a+1;
                // the result must show after that edge plus four more.
                checks++;
                if (acc_q.size() == 0 || cyc - acc_q[0] !== 5) begin
                    $display("FAIL b2b_latency[%0d]: result %0d edges after accept edge, required 4", recv,
                             (acc_q.size() != 0) ? cyc - acc_q[0] - 1 : -1);
                end else passes++;
                if (sent < 6) begin
                    checks++;
                    if (in_ready !== 1'b1) $display("FAIL b2b_coincide[%0d]: in_ready=%b at consume, required 1", recv, in_ready);
                    else passes++;
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                if (acc_q.size() != 0) void'(acc_q.pop_front());
                $display("b2b result %0d: y=%h at cycle %0d", recv, y_out, cyc);
                recv++;
            end else if (in_valid && in_ready && sent > 0) begin
                checks++;
                $display("FAIL b2b_early_accept[%0d]: in_ready=1 with no result consumed, required 0", sent);
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ylist[sent]);
                acc_q.push_back(cyc);
                sent++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (recv !== 6) $display("FAIL b2b_count: received %0d, required 6", recv);
        else passes++;
    endtask

    task automatic test_reset_mid_op();
        int  wait_cyc;
        int  cyc;
        int  lat;
        bit  er;
        bit  ev;
        bit  stale;
        in_valid  = 1'b1;
        z_in      = 32'h5B01EF5B;
        out_ready = 1'b1;
        #1;
        wait_cyc = 0;
        while (!in_ready && wait_cyc < 50) begin
            @(posedge clk);
            #2;
            wait_cyc++;
        end
        checks++;
        if (wait_cyc >= 50) $display("FAIL mid_accept_wait: in_ready stayed %b, required 1", in_ready);
        else passes++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, init_done, in_ready} !== 3'b000 || y_out !== 32'h0) begin
            $display("FAIL mid_reset_state: out_valid=%b init_done=%b in_ready=%b y_out=%h, required 0 0 0 00000000",
                     out_valid, init_done, in_ready, y_out);
        end else passes++;
        wait_init(cyc, er, ev);
        checks++;
        if (cyc !== base_init || er !== 1'b0 || ev !== 1'b0) begin
            $display("FAIL mid_reinit: cycles=%0d ready_seen=%b valid_seen=%b, required %0d 0 0", cyc, er, ev, base_init);
        end else passes++;
        stale = 1'b0;
        out_ready = 1'b1;
        repeat (8) begin
            if (out_valid) stale = 1'b1;
            @(posedge clk);
            #1;
        end
        out_ready = 1'b0;
        checks++;
        if (stale !== 1'b0) $display("FAIL mid_stale: out_valid seen=%b after reinit, required 0", stale);
        else passes++;
        in_valid = 1'b1;
        z_in     = 32'h015BEFEF;
        #1;
        wait_cyc = 0;
        while (!in_ready && wait_cyc < 50) begin
            @(posedge clk);
            #2;
            wait_cyc++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (out_valid !== 1'b1 || y_out !== 32'h01000000) begin
            $display("FAIL mid_after: out_valid=%b y_out=%h, required 1 01000000", out_valid, y_out);
        end else passes++;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        $display("mid-op reset: reinit %0d cycles, post-reset y=%h", cyc, y_out);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_round_trip();
        test_back_to_back();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
